// File: rtl/bank_pkg.sv
// Shared widths, requester ids and FSM encoding for the bank RAM access path.
package bank_pkg;

    localparam int BANK_ADDR_W = 10;
    localparam int BANK_DATA_W = 8;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_ISSUE = 1'b1;

endpackage

// File: rtl/bank_arb_pick.sv
// Combinational grant selection between fetch (bit 0) and data (bit 1).
// Round-robin when BANK_ARB_RR_EN is defined, otherwise fixed priority with a starvation guard.
module bank_arb_pick
    import bank_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o,
`ifdef BANK_ARB_RR_EN
    input  req_id_t    rr_ptr_i
`else
    input  logic [3:0] wait_cnt_i
`endif
);

    logic favor_fetch;

`ifdef BANK_ARB_RR_EN
    // On contention the requester that did not win last time goes first.
    assign favor_fetch = (rr_ptr_i == REQ_DATA);
`else
    assign favor_fetch = (wait_cnt_i >= 4'(MAX_WAIT));
`endif

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o = favor_fetch ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Shares bank port A between instruction fetch and data access; registered port, 2-edge read latency.
// Define BANK_ARB_RR_EN for round-robin arbitration instead of fixed priority to the data requester.
module bank_arbiter
    import bank_pkg::*;
#(
    parameter int ADDR_W   = BANK_ADDR_W,
    parameter int DATA_W   = BANK_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);

    logic [1:0]        grant;
    logic              handshake;
    req_id_t           win_id;

    state_t            state_q, state_d;
    req_id_t           tag_q, tag_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              rsp_vld_q, rsp_vld_d;
    req_id_t           rsp_tag_q, rsp_tag_d;

`ifdef BANK_ARB_RR_EN
    req_id_t           ptr_q, ptr_d;
`else
    logic [3:0]        wait_q, wait_d;
`endif

    bank_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .valid_i    ({req1_valid, req0_valid}),
        .grant_o    (grant),
`ifdef BANK_ARB_RR_EN
        .rr_ptr_i   (ptr_q)
`else
        .wait_cnt_i (wait_q)
`endif
    );

    // Readies are held low while reset is asserted, even if requesters are already valid.
    assign req0_ready = rst_n & grant[0];
    assign req1_ready = rst_n & grant[1];
    assign handshake  = req0_ready | req1_ready;
    assign win_id     = req1_ready ? REQ_DATA : REQ_FETCH;

    always_comb begin
        state_d = handshake ? ST_ISSUE : ST_IDLE;
        tag_d   = tag_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        if (req1_ready) begin
            tag_d   = REQ_DATA;
            wea_d   = req1_we;
            addra_d = req1_addr;
            dina_d  = req1_wdata;
        end else if (req0_ready) begin
            tag_d   = REQ_FETCH;
            wea_d   = req0_we;
            addra_d = req0_addr;
            dina_d  = req0_wdata;
        end
    end

    // The access on the port this cycle is answered next cycle, when douta holds its result.
    assign rsp_vld_d = (state_q == ST_ISSUE);
    assign rsp_tag_d = tag_q;

`ifdef BANK_ARB_RR_EN
    assign ptr_d = handshake ? win_id : ptr_q;
`else
    always_comb begin
        wait_d = wait_q;
        if (req0_ready) begin
            wait_d = 4'd0;
        end else if (req0_valid && handshake && wait_q != 4'hF) begin
            wait_d = wait_q + 4'd1;
        end
    end
`endif

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tag_q     <= REQ_FETCH;
            wea_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            rsp_vld_q <= 1'b0;
            rsp_tag_q <= REQ_FETCH;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            wea_q     <= wea_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

`ifdef BANK_ARB_RR_EN
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) ptr_q <= REQ_FETCH;
        else        ptr_q <= ptr_d;
    end
`else
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) wait_q <= 4'd0;
        else        wait_q <= wait_d;
    end
`endif

    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign rsp0_valid = rsp_vld_q && (rsp_tag_q == REQ_FETCH);
    assign rsp1_valid = rsp_vld_q && (rsp_tag_q == REQ_DATA);
    assign rsp_rdata  = douta;

endmodule

// File: tb/tb_bank_arbiter.sv
// Randomized self-checking bench for bank_arbiter with a behavioural arbitration/response model.
module tb_bank_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MW = 4;

    logic          clka = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0v = 1'b0, r0r, r0we = 1'b0;
    logic [AW-1:0] r0a = '0;
    logic [DW-1:0] r0d = '0;
    logic          r1v = 1'b0, r1r, r1we = 1'b0;
    logic [AW-1:0] r1a = '0;
    logic [DW-1:0] r1d = '0;
    logic          rsp0v, rsp1v, wea;
    logic [DW-1:0] rsp_rdata, dina, douta;
    logic [AW-1:0] addra;

    bank_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .req0_valid (r0v),
        .req0_ready (r0r),
        .req0_we    (r0we),
        .req0_addr  (r0a),
        .req0_wdata (r0d),
        .req1_valid (r1v),
        .req1_ready (r1r),
        .req1_we    (r1we),
        .req1_addr  (r1a),
        .req1_wdata (r1d),
        .rsp0_valid (rsp0v),
        .rsp1_valid (rsp1v),
        .rsp_rdata  (rsp_rdata),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .douta      (douta)
    );

    always #5 clka = ~clka;

    // Bank port A: 1-cycle read latency, read-first.
    logic [DW-1:0] bram [1024];
    always @(posedge clka) begin
        douta <= bram[addra];
        if (wea) bram[addra] <= dina;
    end

    // Reference model state.
    typedef struct {
        int            due;
        int            id;
        logic          we;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] ref_mem [1024];
    rsp_t          rsp_q[$];
    int            waited = 0;
    int            last_id = 0;
    int            cyc = 0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_din = '0;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 1023));
        return AW'($urandom_range(1016, 1023));
    endfunction

    task automatic model_reset();
        rsp_q.delete();
        waited    = 0;
        last_id   = 0;
        prev_we   = 1'b0;
        prev_addr = '0;
        prev_din  = '0;
    endtask

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic step();
        logic g0, g1, e0, e1;
        rsp_t h;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (r0v && r1v) begin
`ifdef BANK_ARB_RR_EN
            if (last_id == 1) g0 = 1'b1; else g1 = 1'b1;
`else
            if (waited >= MW) g0 = 1'b1; else g1 = 1'b1;
`endif
        end else begin
            g0 = r0v;
            g1 = r1v;
        end
        check("ready0", r0r, g0);
        check("ready1", r1r, g1);
        check("one_ready", r0r & r1r, 1'b0);
        check("wea", wea, prev_we);
        check("addra", addra, prev_addr);
        check("dina", dina, prev_din);
        e0 = 1'b0;
        e1 = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            h = rsp_q.pop_front();
            if (h.id == 0) e0 = 1'b1; else e1 = 1'b1;
            if (!h.we) check("rsp_rdata", rsp_rdata, h.data);
        end
        check("rsp0_valid", rsp0v, e0);
        check("rsp1_valid", rsp1v, e1);

        prev_we = 1'b0;
        if (g0 || g1) begin
            h.due  = cyc + 2;
            h.id   = g1 ? 1 : 0;
            h.we   = g1 ? r1we : r0we;
            prev_addr = g1 ? r1a : r0a;
            prev_din  = g1 ? r1d : r0d;
            h.data = ref_mem[prev_addr];
            if (h.we) ref_mem[prev_addr] = prev_din;
            prev_we = h.we;
            last_id = h.id;
            rsp_q.push_back(h);
        end
        if (g0) waited = 0;
        else if (r0v) waited++;

        @(posedge clka);
        @(negedge clka);
        cyc++;
        if (g0) r0v = 1'b0;
        if (g1) r1v = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = 8'($urandom);
            ref_mem[i] = bram[i];
        end
        bram[5]    = 8'hA5;
        ref_mem[5] = 8'hA5;

        // Reset state, with a request already pending.
        r0v = 1'b1;
        repeat (2) @(negedge clka);
        check("rst_ready0", r0r, 1'b0);
        check("rst_wea", wea, 1'b0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        check("rst_rsp0", rsp0v, 1'b0);
        check("rst_rsp1", rsp1v, 1'b0);
        r0v   = 1'b0;
        rst_n = 1'b1;

        // Read of preloaded 0x005 by fetch.
        r0v = 1'b1; r0we = 1'b0; r0a = 10'h005;
        repeat (4) step();

        // Data write 0x3FF <- 0x5C, then fetch read of 0x3FF.
        r1v = 1'b1; r1we = 1'b1; r1a = 10'h3FF; r1d = 8'h5C;
        step();
        r0v = 1'b1; r0we = 1'b0; r0a = 10'h3FF;
        repeat (4) step();

        // Both requesters continuously valid.
        repeat (30) begin
            if (!r0v) begin r0v = 1'b1; r0we = 1'b0; r0a = AW'($urandom_range(0, 1023)); end
            if (!r1v) begin r1v = 1'b1; r1we = 1'b0; r1a = AW'($urandom_range(0, 1023)); end
            step();
        end
        repeat (6) step();

        // Reset one cycle after a fetch read handshake: the response must be dropped.
        r0v = 1'b1; r0we = 1'b0; r0a = 10'h005;
        step();
        r0v = 1'b1; r1v = 1'b1; r1we = 1'b1; r1a = 10'h3FF;
        rst_n = 1'b0;
        #1;
        check("midrst_wea", wea, 1'b0);
        check("midrst_ready0", r0r, 1'b0);
        check("midrst_ready1", r1r, 1'b0);
        repeat (3) begin
            @(negedge clka);
            check("midrst_rsp0", rsp0v, 1'b0);
            check("midrst_rsp1", rsp1v, 1'b0);
            check("midrst_ready0", r0r, 1'b0);
        end
        r0v = 1'b0; r1v = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_addra", addra, 0);
        check("post_rst_dina", dina, 0);
        check("post_rst_wea", wea, 1'b0);
        check("post_rst_rsp0", rsp0v, 1'b0);
        model_reset();
        cyc += 10;
        repeat (3) step();

        // Random traffic with idle gaps and read-after-write hazards.
        repeat (400) begin
            if (!r0v && $urandom_range(0, 3) != 0) begin
                r0v = 1'b1; r0we = 1'($urandom_range(0, 1));
                r0a = rand_addr(); r0d = 8'($urandom);
            end
            if (!r1v && $urandom_range(0, 2) != 0) begin
                r1v = 1'b1; r1we = 1'($urandom_range(0, 1));
                r1a = rand_addr(); r1d = 8'($urandom);
            end
            step();
        end
        repeat (8) step();
        check("scoreboard_empty", 32'(rsp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
